// File: rtl/booth_product_accumulator_pkg.sv
// Shared definitions for the Booth product accumulator: FSM state enum,
// default widths and signed range helpers used by the clamp/fit logic.
// No ports. All widths handled by the helpers must be <= 64.
package booth_acc_pkg;

  localparam int unsigned PROD_W_DEF  = 32;
  localparam int unsigned ACC_W_DEF   = 40;
  localparam int unsigned OUT_W_DEF   = 32;
  localparam int unsigned COUNT_W_DEF = 8;

  // ACCUM: collecting terms; HOLD: result pending with no group open.
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Largest signed value representable in w bits.
  function automatic logic signed [63:0] smax(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in w bits.
  function automatic logic signed [63:0] smin(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // True when v lies inside the w-bit signed range.
  function automatic logic fits(input logic signed [63:0] v, input int unsigned w);
    return (v >= smin(w)) && (v <= smax(w));
  endfunction

endpackage

// File: rtl/booth_product_accumulator_if.sv
// Product-in / result-out handshake bundle of the Booth product accumulator.
// master: upstream producer + downstream consumer side (drives in_*, out_ready).
// slave : accumulator side (drives in_ready, out_*).
interface booth_product_accumulator_if
  import booth_acc_pkg::*;
#(
  parameter int unsigned PROD_W  = PROD_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter int unsigned COUNT_W = COUNT_W_DEF
);

  logic                      in_valid;
  logic                      in_ready;
  logic signed [PROD_W-1:0]  in_product;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_sum;
  logic [COUNT_W-1:0]        out_count;
  logic                      out_overflow;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );

endinterface

// File: rtl/booth_product_accumulator_sat.sv
// booth_acc_sat: combinational signed width reduction IN_W -> OUT_W.
// Ports: din (IN_W signed), dout (OUT_W signed), fit (din within OUT_W range).
// With BOOTH_ACC_SAT_EN defined dout clamps to the OUT_W signed range,
// otherwise dout is the plain truncation of din.
module booth_acc_sat
  import booth_acc_pkg::*;
#(
  parameter int unsigned IN_W  = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    fit
);

  logic signed [63:0] din_ext;

  // Range check on the sign-extended value, then clamp or truncate.
  always_comb begin
    din_ext = 64'(din);
    fit     = fits(din_ext, OUT_W);
`ifdef BOOTH_ACC_SAT_EN
    if (fit) begin
      dout = din[OUT_W-1:0];
    end else if (din[IN_W-1]) begin
      dout = OUT_W'(smin(OUT_W));
    end else begin
      dout = OUT_W'(smax(OUT_W));
    end
`else
    dout = din[OUT_W-1:0];
`endif
  end

endmodule

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: sums groups of signed Booth products (delimited
// by in_last) into an ACC_W accumulator and emits one registered OUT_W result
// per group with term count and overflow flag.
// Ports: clk, rst (async, active-high), bus (slave modport: in_valid/in_ready/
// in_product/in_last, out_valid/out_ready/out_sum/out_count/out_overflow).
// Build option: BOOTH_ACC_SAT_EN selects saturating accumulate and output
// clamp instead of wrap/truncate. in_ready is combinational by design.
module booth_product_accumulator
  import booth_acc_pkg::*;
#(
  parameter int unsigned PROD_W  = PROD_W_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter int unsigned COUNT_W = COUNT_W_DEF
) (
  input logic                         clk,
  input logic                         rst,
  booth_product_accumulator_if.slave  bus
);

  state_t                    state, state_next;
  logic signed [ACC_W-1:0]   acc, acc_next;
  logic [COUNT_W-1:0]        cnt, cnt_next;
  logic                      ovf, ovf_next;
  logic                      out_valid_q, out_valid_next;
  logic signed [OUT_W-1:0]   out_sum_q, out_sum_next;
  logic [COUNT_W-1:0]        out_count_q, out_count_next;
  logic                      out_overflow_q, out_overflow_next;

  logic                      beat;
  logic                      take;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   grp_sum;
  logic [COUNT_W-1:0]        grp_cnt;
  logic                      add_ovf;
  logic signed [OUT_W-1:0]   res_sum;
  logic                      res_fit;

  assign bus.in_ready     = !out_valid_q || bus.out_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_overflow = out_overflow_q;

  assign beat     = bus.in_valid && bus.in_ready;
  assign take     = out_valid_q && bus.out_ready;
  assign prod_ext = ACC_W'(bus.in_product);
  assign grp_cnt  = (&cnt) ? cnt : cnt + COUNT_W'(1);

`ifdef BOOTH_ACC_SAT_EN
  // One guard bit makes the true sum exact; the clamp's fit flag is the overflow.
  logic signed [ACC_W:0] sum_wide;
  logic                  acc_fit;

  assign sum_wide = (ACC_W + 1)'(acc) + (ACC_W + 1)'(prod_ext);
  assign add_ovf  = !acc_fit;

  booth_acc_sat #(
    .IN_W  (ACC_W + 1),
    .OUT_W (ACC_W)
  ) u_acc_sat (
    .din  (sum_wide),
    .dout (grp_sum),
    .fit  (acc_fit)
  );
`else
  // Wrapping add; overflow when operand signs agree and the result sign differs.
  assign grp_sum = acc + prod_ext;
  assign add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                   (grp_sum[ACC_W-1] != acc[ACC_W-1]);
`endif

  booth_acc_sat #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W)
  ) u_out_sat (
    .din  (grp_sum),
    .dout (res_sum),
    .fit  (res_fit)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ACCUM;
      acc            <= '0;
      cnt            <= '0;
      ovf            <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sum_q      <= '0;
      out_count_q    <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state          <= state_next;
      acc            <= acc_next;
      cnt            <= cnt_next;
      ovf            <= ovf_next;
      out_valid_q    <= out_valid_next;
      out_sum_q      <= out_sum_next;
      out_count_q    <= out_count_next;
      out_overflow_q <= out_overflow_next;
    end
  end

  // Next-state, accumulate and result-load logic.
  always_comb begin
    state_next        = state;
    acc_next          = acc;
    cnt_next          = cnt;
    ovf_next          = ovf;
    out_valid_next    = out_valid_q;
    out_sum_next      = out_sum_q;
    out_count_next    = out_count_q;
    out_overflow_next = out_overflow_q;

    if (take) begin
      out_valid_next = 1'b0;
    end

    if (beat) begin
      if (bus.in_last) begin
        // Close the group: publish the result and reopen an empty accumulator.
        out_valid_next    = 1'b1;
        out_sum_next      = res_sum;
        out_count_next    = grp_cnt;
        out_overflow_next = ovf || add_ovf || !res_fit;
        acc_next          = '0;
        cnt_next          = '0;
        ovf_next          = 1'b0;
      end else begin
        acc_next = grp_sum;
        cnt_next = grp_cnt;
        ovf_next = ovf || add_ovf;
      end
    end

    case (state)
      ACCUM: begin
        if (beat && bus.in_last) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (beat && !bus.in_last) begin
          state_next = ACCUM;
        end else if (take && !beat) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Directed self-checking bench for booth_product_accumulator (default widths).
module tb_booth_product_accumulator;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  booth_product_accumulator_if #(.PROD_W(32), .OUT_W(32), .COUNT_W(8)) bus ();

  booth_product_accumulator #(
    .PROD_W  (32),
    .ACC_W   (40),
    .OUT_W   (32),
    .COUNT_W (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Present one beat and return 1 time unit after the edge that accepts it.
  task automatic send(input logic signed [31:0] p, input logic l);
    logic got_rdy;
    got_rdy        = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    bus.in_last    = l;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got_rdy = 1'b1;
        break;
      end
    end
    if (!got_rdy) check("send_ready_timeout", 64'(got_rdy), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic signed [63:0] big_exp;
    errors         = 0;
    checks         = 0;
    clk            = 1'b0;
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_out_sum", 64'(bus.out_sum), 0);
    check("rst_out_count", 64'(bus.out_count), 0);
    check("rst_out_overflow", 64'(bus.out_overflow), 0);
    check("rst_in_ready", 64'(bus.in_ready), 1);

    // Basic 3-term group: 100 - 30 + 7 = 77.
    @(posedge clk); #1;
    send(100, 1'b0);
    send(-30, 1'b0);
    check("g1_no_early_valid", 64'(bus.out_valid), 0);
    send(7, 1'b1);
    check("g1_valid", 64'(bus.out_valid), 1);
    check("g1_sum", 64'(bus.out_sum), 77);
    check("g1_count", 64'(bus.out_count), 3);
    check("g1_ovf", 64'(bus.out_overflow), 0);
    @(posedge clk); #1;
    check("g1_valid_drop", 64'(bus.out_valid), 0);

    // 4 x 0x40000000 = 2^32: fits 40 bits, not 32.
`ifdef BOOTH_ACC_SAT_EN
    big_exp = 64'sh7FFFFFFF;
`else
    big_exp = 0;
`endif
    for (int i = 0; i < 4; i++) send(32'sh40000000, i == 3);
    check("big_valid", 64'(bus.out_valid), 1);
    check("big_sum", 64'(bus.out_sum), big_exp);
    check("big_count", 64'(bus.out_count), 4);
    check("big_ovf", 64'(bus.out_overflow), 1);
    @(posedge clk); #1;

    // Back-to-back single-term groups.
    send(-5, 1'b1);
    check("b2b_a_valid", 64'(bus.out_valid), 1);
    check("b2b_a_sum", 64'(bus.out_sum), -5);
    check("b2b_a_count", 64'(bus.out_count), 1);
    send(9, 1'b1);
    check("b2b_b_valid", 64'(bus.out_valid), 1);
    check("b2b_b_sum", 64'(bus.out_sum), 9);
    check("b2b_b_count", 64'(bus.out_count), 1);
    @(posedge clk); #1;
    check("b2b_valid_drop", 64'(bus.out_valid), 0);

    // Backpressure: 11 + 22 pending while a further last-beat waits.
    bus.out_ready = 1'b0;
    send(11, 1'b0);
    send(22, 1'b1);
    bus.in_valid   = 1'b1;
    bus.in_product = 1000;
    bus.in_last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(bus.in_ready), 0);
      check("stall_valid", 64'(bus.out_valid), 1);
      check("stall_sum", 64'(bus.out_sum), 33);
      check("stall_count", 64'(bus.out_count), 2);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", 64'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("release_next_valid", 64'(bus.out_valid), 1);
    check("release_next_sum", 64'(bus.out_sum), 1000);
    check("release_next_count", 64'(bus.out_count), 1);
    @(posedge clk); #1;
    check("release_drop", 64'(bus.out_valid), 0);

    // Reset mid-group discards the partial sum.
    send(50, 1'b0);
    send(60, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_no_valid", 64'(bus.out_valid), 0);
    send(1, 1'b0);
    check("abort_no_valid2", 64'(bus.out_valid), 0);
    send(2, 1'b1);
    check("abort_sum", 64'(bus.out_sum), 3);
    check("abort_count", 64'(bus.out_count), 2);
    check("abort_ovf", 64'(bus.out_overflow), 0);
    @(posedge clk); #1;

    // Count saturation: 300 terms of 1.
    for (int i = 0; i < 300; i++) send(1, i == 299);
    check("sat_valid", 64'(bus.out_valid), 1);
    check("sat_sum", 64'(bus.out_sum), 300);
    check("sat_count", 64'(bus.out_count), 255);
    check("sat_ovf", 64'(bus.out_overflow), 0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_product_accumulator.md
# booth_product_accumulator

Downstream consumer of the registered 16x16 signed Booth multiplier stage. Takes the stream of 32-bit signed products over a valid/ready handshake and accumulates each group, delimited by `in_last`, into a wide signed accumulator. It presents one registered, width-reduced dot-product result per group over a second valid/ready handshake. This is the MAC back end for the multiplier datapath.

## Interface
Parameters:
- `PROD_W`, 32: signed product width (multiplier output).
- `ACC_W`, 40: internal accumulator width, ≥ `PROD_W`.
- `OUT_W`, 32: result width, ≤ `ACC_W`.
- `COUNT_W`, 8: term-counter width.

Ports:
- `clk` input 1: clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: product valid.
- `in_ready` output 1: product accepted when `in_valid & in_ready`.
- `in_product` input `PROD_W`: signed product.
- `in_last` input 1: product is final term of its group.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts result.
- `out_sum` output `OUT_W`: signed group sum.
- `out_count` output `COUNT_W`: terms in group, saturating at 2^COUNT_W-1.
- `out_overflow` output 1: group overflowed `ACC_W` or did not fit `OUT_W`.

## Operation
- States (shared package enum): `ACCUM` (collecting terms) and `HOLD` (result pending, no group open). A group in progress while a result is pending is tracked by `acc`/`cnt`, not by state.
- `in_ready = !out_valid | out_ready`. A pending result blocks input only while downstream stalls.
- On an accepted beat:
  - `acc_next = acc + sext(in_product)` at `ACC_W`.
  - `cnt` increments, saturating.
  - The sticky `ovf` bit sets on signed overflow of the addition: operand signs equal and result sign differs.
- On an accepted beat with `in_last=1`:
  - `out_sum`, `out_count` and `out_overflow` load from `acc_next`, `cnt+1` and `ovf_next | !fits(acc_next, OUT_W)`.
  - `out_valid` is set.
  - `acc`, `cnt` and `ovf` clear to 0 in the same edge.
- Output handshake:
  - `out_valid` clears on `out_valid & out_ready`, unless a new last-beat is accepted in the same cycle. In that case the new result loads and `out_valid` stays 1, giving back-to-back results with no bubble.
  - Output registers are stable while `out_valid & !out_ready`.
- A single-term group (`in_last` on the first beat) is legal: `out_count=1`.
- Reset mid-group discards the partial sum; no result is emitted.

## Timing
- Reset values: `out_valid=0`, `out_sum=0`, `out_count=0`, `out_overflow=0`, `in_ready=1`; internally `acc=0`, `cnt=0`, `ovf=0`, state `ACCUM`.
- Latency: last beat accepted at edge t → `out_valid=1` after edge t, visible in cycle t+1.
- Throughput: one product per cycle while `out_ready` is held high.
- Backpressure: with `out_valid=1` and `out_ready=0`, `in_ready=0` the same cycle (combinational from registered `out_valid` and the `out_ready` input).
- There is no combinational path from `in_*` to `out_*`.

## Configuration
- `BOOTH_ACC_SAT_EN` defined:
  - Each accumulate clamps to the `ACC_W` signed range instead of wrapping.
  - `out_sum` clamps `acc_next` to the `OUT_W` signed range: max 2^(OUT_W-1)-1, min -2^(OUT_W-1).
- Undefined:
  - Accumulator wraps modulo 2^ACC_W.
  - `out_sum = acc_next[OUT_W-1:0]` (truncation).
- `out_overflow` semantics are identical in both builds.

## Structure
- Package `booth_acc_pkg`: state enum, default width localparams, `fits`/signed-min/max helper functions.
- One sub-module, `booth_acc_sat`: combinational signed clamp/truncate from `ACC_W` to `OUT_W` with a fit flag. It is instantiated for the output path; the accumulate path reuses it with `OUT_W=ACC_W` when `BOOTH_ACC_SAT_EN` is defined.
- Top holds the FSM, registers and handshake logic.

## Test plan
- Products 100, -30, 7 (last on 7), `out_ready=1` → one cycle later `out_sum=77`, `out_count=3`, `out_overflow=0`, `out_valid` for 1 cycle.
- Four products 0x40000000 (from -32768×-32768), last on the 4th:
  - With SAT_EN → `out_sum=0x7FFFFFFF`, `out_overflow=1`, `out_count=4`.
  - Without → `out_sum=0x00000000`, `out_overflow=1`.
- Single-term group of -5 immediately followed by a single-term group of 9, `out_ready=1` → results -5 then 9 on consecutive cycles, `out_valid` never drops.
- Result pending with `out_ready=0` for 5 cycles → `in_ready=0`, `out_sum`/`out_count` stable; raise `out_ready` → accepted, `in_ready=1` same cycle.
- `rst` pulse after 2 of 3 terms, then group 1, 2 (last) → result 3, `out_count=2`; no result from the aborted group.
- 300 terms of 1 with `COUNT_W=8` → `out_sum=300`, `out_count=255`, `out_overflow=0`.
